tone_arbiter: RTL and testbench

//  Shares the single speaker tone generator between several tone sources:
//  win/lose jingle, sequence playback, and button-press feedback.

---
 rtl/simon_sound_pkg.sv | 21 ++
 rtl/tone_prio_enc.sv | 29 ++
 rtl/tone_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_tone_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_sound_pkg.sv
// Shared types and default timing constants for the Simon sound path.
package simon_sound_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_PLAY,
      ARB_GAP
   } arb_state_t;

   localparam int CLK_HZ         = 50_000_000;
   // 50 ms minimum tone, 10 ms silent gap between owners.
   localparam int DEF_MIN_HOLD   = CLK_HZ / 20;
   localparam int DEF_GAP_CYCLES = CLK_HZ / 100;
   localparam int DEF_CNT_W      = 24;

   // Width of an index into n requesters; never zero, even for a single requester.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tone_prio_enc.sv
// Fixed-priority encoder: picks the lowest set bit of mask.
// Returns it as a one-hot vector and as a binary index; valid flags a non-empty mask.
module tone_prio_enc
   import simon_sound_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int IDX_W = idx_width(NREQ)
) (
   input  logic [NREQ-1:0]  mask,
   output logic [NREQ-1:0]  onehot,
   output logic [IDX_W-1:0] index,
   output logic             valid
);

   // Scan from the top down so the lowest set bit is the one that sticks.
   always_comb begin
      onehot = '0;
      index  = '0;
      valid  = |mask;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (mask[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            index     = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/tone_arbiter.sv
// Speaker tone arbiter: shares one tone generator between several sources
// using fixed priority (index 0 highest) and a minimum hold per grant.
// Optional build macro TONE_GAP_EN inserts a silent gap between owners.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ARB_IDLE | no owner, speaker silent, arbitrating every cycle
//  ARB_PLAY | owner_q holds the speaker; hold counter runs to MIN_HOLD-1
//  ARB_GAP  | silent, no owner, busy; GAP_CYCLES long (TONE_GAP_EN only)
module tone_arbiter
   import simon_sound_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int FREQ_W     = 32,
   parameter int MIN_HOLD   = DEF_MIN_HOLD,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*FREQ_W-1:0] req_freq,
   output logic [NREQ-1:0]        grant,
   output logic [NREQ-1:0]        done,
   output logic                   busy,
   output logic [FREQ_W-1:0]      freq
);

   localparam int IDX_W = idx_width(NREQ);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD - 1);
   // Only reachable with TONE_GAP_EN; without it the GAP arm below is dead logic.
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   arb_state_t         state_q, state_d;
   logic [NREQ-1:0]    grant_q, grant_d;
   logic [NREQ-1:0]    done_q, done_d;
   logic               busy_q, busy_d;
   logic [FREQ_W-1:0]  freq_q, freq_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   owner_q, owner_d;

   logic [FREQ_W-1:0]  freq_arr [NREQ];
   logic [NREQ-1:0]    arb_mask, pre_mask;
   logic [NREQ-1:0]    arb_onehot, pre_onehot;
   logic [IDX_W-1:0]   arb_idx, pre_idx;
   logic               arb_valid, pre_valid;
   logic [FREQ_W-1:0]  arb_freq, pre_freq, owner_freq;
   logic               own_req;
   logic               hold_done;

   // Unpack the frequency bus and derive arbitration masks.
   // grant_q - 1 turns the one-hot owner into a mask of all higher-priority slots.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         freq_arr[i] = req_freq[i*FREQ_W +: FREQ_W];
      end
      arb_mask   = req & ~grant_q;
      pre_mask   = req & (grant_q - NREQ'(1));
      own_req    = |(req & grant_q);
      hold_done  = (cnt_q == HOLD_LAST);
      arb_freq   = freq_arr[arb_idx];
      pre_freq   = freq_arr[pre_idx];
      owner_freq = freq_arr[owner_q];
   end

   tone_prio_enc #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb_enc (
      .mask   (arb_mask),
      .onehot (arb_onehot),
      .index  (arb_idx),
      .valid  (arb_valid)
   );

   tone_prio_enc #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pre_enc (
      .mask   (pre_mask),
      .onehot (pre_onehot),
      .index  (pre_idx),
      .valid  (pre_valid)
   );

   // Next-state, next-owner and registered output values.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      done_d  = '0;
      busy_d  = busy_q;
      freq_d  = freq_q;
      cnt_d   = cnt_q;
      case (state_q)
         ARB_IDLE: begin
            grant_d = '0;
            busy_d  = 1'b0;
            freq_d  = '0;
            cnt_d   = '0;
            if (arb_valid) begin
               state_d = ARB_PLAY;
               grant_d = arb_onehot;
               owner_d = arb_idx;
               busy_d  = 1'b1;
               freq_d  = arb_freq;
            end
         end
         ARB_PLAY: begin
            busy_d = 1'b1;
            // Keep following the owner's live word, even after its req has dropped.
            freq_d = owner_freq;
            if (!hold_done) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // Preemption is checked first so it beats a simultaneous release (no done).
            if (hold_done && pre_valid) begin
`ifdef TONE_GAP_EN
               state_d = ARB_GAP;
               grant_d = '0;
               freq_d  = '0;
               cnt_d   = '0;
`else
               grant_d = pre_onehot;
               owner_d = pre_idx;
               freq_d  = pre_freq;
               cnt_d   = '0;
`endif
            end else if (hold_done && !own_req) begin
               done_d = grant_q;
`ifdef TONE_GAP_EN
               state_d = ARB_GAP;
               grant_d = '0;
               freq_d  = '0;
               cnt_d   = '0;
`else
               cnt_d = '0;
               if (arb_valid) begin
                  grant_d = arb_onehot;
                  owner_d = arb_idx;
                  freq_d  = arb_freq;
               end else begin
                  state_d = ARB_IDLE;
                  grant_d = '0;
                  busy_d  = 1'b0;
                  freq_d  = '0;
               end
`endif
            end
         end
         ARB_GAP: begin
            grant_d = '0;
            freq_d  = '0;
            busy_d  = 1'b1;
            // Arbitrate on the last gap cycle so the silence is exactly GAP_CYCLES long.
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (arb_valid) begin
                  state_d = ARB_PLAY;
                  grant_d = arb_onehot;
                  owner_d = arb_idx;
                  freq_d  = arb_freq;
               end else begin
                  state_d = ARB_IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ARB_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            freq_d  = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // State and output registers; async reset clears everything immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         owner_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         freq_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         freq_q  <= freq_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant = grant_q;
   assign done  = done_q;
   assign busy  = busy_q;
   assign freq  = freq_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Scoreboard bench for tone_arbiter (NREQ=4, MIN_HOLD=4, GAP_CYCLES=3).
// Expected output-change events are queued when stimulus is driven and
// matched, cycle-exact, whenever grant/done/busy/freq change.
module tb_tone_arbiter;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [3:0]   req;
   logic [31:0]  rf [4];
   logic [127:0] req_freq;
   logic [3:0]   grant, done;
   logic         busy;
   logic [31:0]  freq;

   typedef struct {
      int          cyc;
      logic [3:0]  grant;
      logic [3:0]  done;
      logic        busy;
      logic [31:0] freq;
   } ev_t;

   ev_t        sb_q[$];
   ev_t        mon_e;
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   bit         mon_en = 1'b0;
   logic [40:0] mon_prev;
   int         n;

   assign req_freq = {rf[3], rf[2], rf[1], rf[0]};

   always #10 clk = ~clk;

   always @(posedge clk) cyc++;

   tone_arbiter #(
      .NREQ(4), .FREQ_W(32), .MIN_HOLD(4), .GAP_CYCLES(3), .CNT_W(4)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .req_freq (req_freq),
      .grant    (grant),
      .done     (done),
      .busy     (busy),
      .freq     (freq)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_ev(input int c, input logic [3:0] g, input logic [3:0] d,
                          input logic b, input logic [31:0] f);
      ev_t e;
      e.cyc = c; e.grant = g; e.done = d; e.busy = b; e.freq = f;
      sb_q.push_back(e);
   endtask

   task automatic at(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic drain_chk(input string tag);
      chk(tag, 64'(sb_q.size()), 64'(0));
      sb_q.delete();
   endtask

   // Output monitor: every change of the observable tuple must match the next queued event.
   always @(negedge clk) begin
      if (mon_en && ({grant, done, busy, freq} !== mon_prev)) begin
         if (sb_q.size() == 0) begin
            chk("sb_extra_event", {23'b0, grant, done, busy, freq}, {23'b0, mon_prev});
         end else begin
            mon_e = sb_q.pop_front();
            chk("ev_cyc",   64'(cyc),   64'(mon_e.cyc));
            chk("ev_grant", 64'(grant), 64'(mon_e.grant));
            chk("ev_done",  64'(done),  64'(mon_e.done));
            chk("ev_busy",  64'(busy),  64'(mon_e.busy));
            chk("ev_freq",  64'(freq),  64'(mon_e.freq));
         end
         mon_prev = {grant, done, busy, freq};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      req     = '0;
      for (int i = 0; i < 4; i++) rf[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_done",  64'(done),  64'(0));
      chk("rst_busy",  64'(busy),  64'(0));
      chk("rst_freq",  64'(freq),  64'(0));
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_grant", 64'(grant), 64'(0));
      chk("idle_busy",  64'(busy),  64'(0));
      mon_prev = {grant, done, busy, freq};
      mon_en   = 1'b1;

      // Single one-cycle request still gets the full minimum hold.
      @(negedge clk); n = cyc;
      rf[2] = 523; req = 4'b0100;
      push_ev(n+1, 4'b0100, 4'b0000, 1'b1, 523);
`ifdef TONE_GAP_EN
      push_ev(n+5, 4'b0000, 4'b0100, 1'b1, 0);
      push_ev(n+6, 4'b0000, 4'b0000, 1'b1, 0);
      push_ev(n+8, 4'b0000, 4'b0000, 1'b0, 0);
`else
      push_ev(n+5, 4'b0000, 4'b0100, 1'b0, 0);
      push_ev(n+6, 4'b0000, 4'b0000, 1'b0, 0);
`endif
      at(n+1); req = 4'b0000;
      at(n+12); drain_chk("short_req_drain");

      // Zero frequency word is still a real (silent) grant.
      @(negedge clk); n = cyc;
      rf[1] = 0; req = 4'b0010;
      push_ev(n+1, 4'b0010, 4'b0000, 1'b1, 0);
`ifdef TONE_GAP_EN
      push_ev(n+5, 4'b0000, 4'b0010, 1'b1, 0);
      push_ev(n+6, 4'b0000, 4'b0000, 1'b1, 0);
      push_ev(n+8, 4'b0000, 4'b0000, 1'b0, 0);
`else
      push_ev(n+5, 4'b0000, 4'b0010, 1'b0, 0);
      push_ev(n+6, 4'b0000, 4'b0000, 1'b0, 0);
`endif
      at(n+1); req = 4'b0000;
      at(n+12); drain_chk("silent_hold_drain");

      // Contention: req[1] and req[3] together; 1 wins, 3 waits.
      @(negedge clk); n = cyc;
      rf[1] = 392; rf[3] = 330; req = 4'b1010;
      push_ev(n+1, 4'b0010, 4'b0000, 1'b1, 392);
`ifdef TONE_GAP_EN
      push_ev(n+8,  4'b0000, 4'b0010, 1'b1, 0);
      push_ev(n+9,  4'b0000, 4'b0000, 1'b1, 0);
      push_ev(n+11, 4'b1000, 4'b0000, 1'b1, 330);
      push_ev(n+15, 4'b0000, 4'b1000, 1'b1, 0);
      push_ev(n+16, 4'b0000, 4'b0000, 1'b1, 0);
      push_ev(n+18, 4'b0000, 4'b0000, 1'b0, 0);
`else
      push_ev(n+8,  4'b1000, 4'b0010, 1'b1, 330);
      push_ev(n+9,  4'b1000, 4'b0000, 1'b1, 330);
      push_ev(n+13, 4'b0000, 4'b1000, 1'b0, 0);
      push_ev(n+14, 4'b0000, 4'b0000, 1'b0, 0);
`endif
      at(n+7);  req = 4'b1000;
      at(n+12); req = 4'b0000;
      at(n+22); drain_chk("contention_drain");

      // Preemption of req[3] by req[0] once the hold completes; no done to 3.
      @(negedge clk); n = cyc;
      rf[3] = 330; rf[0] = 659; req = 4'b1000;
      push_ev(n+1, 4'b1000, 4'b0000, 1'b1, 330);
      at(n+2); req = 4'b1001;
`ifdef TONE_GAP_EN
      push_ev(n+5,  4'b0000, 4'b0000, 1'b1, 0);
      push_ev(n+8,  4'b0001, 4'b0000, 1'b1, 659);
      push_ev(n+12, 4'b0000, 4'b0001, 1'b1, 0);
      push_ev(n+13, 4'b0000, 4'b0000, 1'b1, 0);
      push_ev(n+15, 4'b1000, 4'b0000, 1'b1, 330);
      push_ev(n+19, 4'b0000, 4'b1000, 1'b1, 0);
      push_ev(n+20, 4'b0000, 4'b0000, 1'b1, 0);
      push_ev(n+22, 4'b0000, 4'b0000, 1'b0, 0);
      at(n+9);  req = 4'b1000;
      at(n+16); req = 4'b0000;
      at(n+27); drain_chk("preempt_drain");
`else
      push_ev(n+5,  4'b0001, 4'b0000, 1'b1, 659);
      push_ev(n+9,  4'b1000, 4'b0001, 1'b1, 330);
      push_ev(n+10, 4'b1000, 4'b0000, 1'b1, 330);
      push_ev(n+13, 4'b0000, 4'b1000, 1'b0, 0);
      push_ev(n+14, 4'b0000, 4'b0000, 1'b0, 0);
      at(n+6);  req = 4'b1000;
      at(n+10); req = 4'b0000;
      at(n+19); drain_chk("preempt_drain");
`endif

      // Live frequency tracking while the grant stays put.
      @(negedge clk); n = cyc;
      rf[0] = 330; req = 4'b0001;
      push_ev(n+1, 4'b0001, 4'b0000, 1'b1, 330);
      at(n+2); rf[0] = 392;
      push_ev(n+3, 4'b0001, 4'b0000, 1'b1, 392);
      at(n+4); rf[0] = 659;
      push_ev(n+5, 4'b0001, 4'b0000, 1'b1, 659);
`ifdef TONE_GAP_EN
      push_ev(n+7,  4'b0000, 4'b0001, 1'b1, 0);
      push_ev(n+8,  4'b0000, 4'b0000, 1'b1, 0);
      push_ev(n+10, 4'b0000, 4'b0000, 1'b0, 0);
`else
      push_ev(n+7, 4'b0000, 4'b0001, 1'b0, 0);
      push_ev(n+8, 4'b0000, 4'b0000, 1'b0, 0);
`endif
      at(n+6); req = 4'b0000;
      at(n+14); drain_chk("live_track_drain");

      // Back-to-back owners req[1] then req[2].
      @(negedge clk); n = cyc;
      rf[1] = 392; rf[2] = 523; req = 4'b0110;
      push_ev(n+1, 4'b0010, 4'b0000, 1'b1, 392);
`ifdef TONE_GAP_EN
      push_ev(n+5,  4'b0000, 4'b0010, 1'b1, 0);
      push_ev(n+6,  4'b0000, 4'b0000, 1'b1, 0);
      push_ev(n+8,  4'b0100, 4'b0000, 1'b1, 523);
      push_ev(n+12, 4'b0000, 4'b0100, 1'b1, 0);
      push_ev(n+13, 4'b0000, 4'b0000, 1'b1, 0);
      push_ev(n+15, 4'b0000, 4'b0000, 1'b0, 0);
`else
      push_ev(n+5,  4'b0100, 4'b0010, 1'b1, 523);
      push_ev(n+6,  4'b0100, 4'b0000, 1'b1, 523);
      push_ev(n+9,  4'b0000, 4'b0100, 1'b0, 0);
      push_ev(n+10, 4'b0000, 4'b0000, 1'b0, 0);
`endif
      at(n+1); req = 4'b0100;
      at(n+8); req = 4'b0000;
      at(n+20); drain_chk("back2back_drain");

      // Async reset in the middle of a grant clears outputs without a clock.
      @(negedge clk); n = cyc;
      rf[3] = 330; req = 4'b1000;
      push_ev(n+1, 4'b1000, 4'b0000, 1'b1, 330);
      at(n+2);
      mon_en = 1'b0;
      chk("pre_rst_grant", 64'(grant), 64'(4'b1000));
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_grant", 64'(grant), 64'(0));
      chk("midrst_done",  64'(done),  64'(0));
      chk("midrst_busy",  64'(busy),  64'(0));
      chk("midrst_freq",  64'(freq),  64'(0));
      drain_chk("midrst_drain");
      req = 4'b0000;
      @(negedge clk); reset_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_grant", 64'(grant), 64'(0));
      chk("post_rst_busy",  64'(busy),  64'(0));
      chk("post_rst_freq",  64'(freq),  64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
